// File: rtl/duck_pkg.sv
// Shared types and default timing for the light-gun conditioning path.
package duck_pkg;

    typedef enum logic [1:0] {
        WAIT    = 2'd0,
        MEASURE = 2'd1,
        DONE    = 2'd2
    } gun_state_t;

    localparam int DEBOUNCE_CYCLES_DEF = 250000;
    localparam int HIT_THRESHOLD_DEF   = 64;

endpackage

// File: rtl/debounce.sv
// Two-flop synchronizer followed by a stability counter; level only follows
// the input after it has stayed different for CYCLES consecutive clocks.
module debounce
    import duck_pkg::*;
#(
    parameter int CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            // Any return to the current level restarts the stability window.
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                level <= sync[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/gun_conditioner.sv
// Light-gun front end: debounced trigger with shot counting, and a per-frame
// photodiode hit detector that reports at most one hit per flash frame.
module gun_conditioner
    import duck_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int HIT_THRESHOLD   = HIT_THRESHOLD_DEF,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trigger_raw,
    input  logic             photo_raw,
    input  logic             frame_tick,
    input  logic             flash_active,
    output logic             trigger,
    output logic             trigger_pulse,
    output logic             detect,
    output logic [CNT_W-1:0] shot_count,
    output logic [CNT_W-1:0] hit_count
);

    localparam int LW = $clog2(HIT_THRESHOLD + 1);
    localparam logic [LW-1:0]    LIGHT_MAX = LW'(HIT_THRESHOLD);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    logic          trigger_prev;
    logic [1:0]    photo_sync;
    gun_state_t    state, state_next;
    logic [LW-1:0] light_cnt, light_next;
    logic          hit_inc;

    debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_trigger_db (
        .clk   (clk),
        .rst   (rst),
        .raw   (trigger_raw),
        .level (trigger)
    );

    assign trigger_pulse = trigger & ~trigger_prev;

    // frame_tick overrides everything so a late threshold crossing never leaks
    // a hit into the next frame.
    always_comb begin
        state_next = state;
        light_next = light_cnt;
        hit_inc    = 1'b0;
        if (frame_tick) begin
            state_next = WAIT;
            light_next = '0;
        end else begin
            case (state)
                WAIT: begin
                    if (flash_active) state_next = MEASURE;
                end
                MEASURE: begin
                    if (photo_sync[1] && flash_active) begin
                        light_next = (light_cnt == LIGHT_MAX) ? LIGHT_MAX : light_cnt + LW'(1);
                        if (light_next == LIGHT_MAX) begin
                            state_next = DONE;
                            hit_inc    = 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_next = DONE;
                end
                default: state_next = WAIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            trigger_prev <= 1'b0;
            photo_sync   <= '0;
            state        <= WAIT;
            light_cnt    <= '0;
            detect       <= 1'b0;
            shot_count   <= '0;
            hit_count    <= '0;
        end else begin
            trigger_prev <= trigger;
            photo_sync   <= {photo_sync[0], photo_raw};
            state        <= state_next;
            light_cnt    <= light_next;
            detect       <= (state_next == DONE);
            if (trigger_pulse) shot_count <= sat_inc(shot_count);
            if (hit_inc)       hit_count  <= sat_inc(hit_count);
        end
    end

endmodule

// File: doc/gun_conditioner.md
GUN_CONDITIONER -- requirements
Module: gun_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 250000: consecutive stable cycles needed to accept a trigger level change (10 ms at 25 MHz).
REQ-002 SHALL have parameter HIT_THRESHOLD, default 64: photodiode-high cycles inside one flash frame that count as a hit.
REQ-003 SHALL have parameter CNT_W, default 8: width of shot_count and hit_count.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 trigger_raw  in  1  asynchronous, bouncy gun trigger switch; 1 = pulled.
REQ-007 photo_raw  in  1  asynchronous photodiode comparator output; 1 = light seen.
REQ-008 frame_tick  in  1  one-cycle pulse once per frame; same event as the game's screen_reset.
REQ-009 flash_active  in  1  high for the whole white-target frame.
REQ-010 trigger  out  1  debounced trigger level, feeds the pattern generator's trigger.
REQ-011 trigger_pulse  out  1  one-cycle pulse on each debounced rising edge.
REQ-012 detect  out  1  registered hit flag for the current flash frame, feeds the pattern generator's detect.
REQ-013 shot_count  out  CNT_W  accepted shots, saturating.
REQ-014 hit_count  out  CNT_W  hits, saturating.

Function
REQ-015 trigger_raw and photo_raw SHALL each pass through a 2-flop synchronizer; all later logic uses only the synchronized versions.
REQ-016 Debounce: a counter SHALL clear whenever sync trigger equals trigger, increment while they differ, and on the cycle it reaches DEBOUNCE_CYCLES-1, trigger SHALL take the sync value on the next edge and the counter SHALL clear.
REQ-017 Any bounce (sync value returns to trigger) before the counter completes SHALL clear the counter with no output change.
REQ-018 trigger_pulse SHALL be high for exactly the one cycle after trigger goes 0->1; no pulse on 1->0.
REQ-019 shot_count SHALL increment by 1 on each trigger_pulse and hold at 2^CNT_W-1.
REQ-020 Hit FSM states: WAIT, MEASURE, DONE.
REQ-021 WAIT->MEASURE when flash_active=1 and frame_tick=0; otherwise stay.
REQ-022 In MEASURE, light_cnt SHALL increment each cycle where sync photo=1 and flash_active=1; light_cnt saturates at HIT_THRESHOLD.
REQ-023 MEASURE->DONE on the cycle light_cnt reaches HIT_THRESHOLD; hit_count SHALL increment once (saturating) on that transition.
REQ-024 MEASURE->WAIT and DONE->WAIT on frame_tick; light_cnt SHALL clear on every frame_tick.
REQ-025 frame_tick SHALL take priority over a same-cycle increment or threshold crossing: the state goes to WAIT and light_cnt to 0, with no hit_count change.
REQ-026 detect SHALL be registered high exactly while the state is DONE, so it is stable at the frame_tick that ends the flash frame and reads 0 on the following cycle.
REQ-027 Photodiode activity while flash_active=0 SHALL never set detect or change light_cnt (room lights, CRT bloom on other frames).
REQ-028 At most one hit SHALL be counted per flash frame, regardless of light duration.

Reset
REQ-029 While rst=1: synchronizers 0; debounce counter 0; trigger, trigger_pulse and detect 0; shot_count, hit_count and light_cnt 0; FSM WAIT.
REQ-030 rst asserted mid-debounce or mid-MEASURE SHALL abandon the operation, with no pulse or count on the release cycle.

Structure
REQ-031 Shared package duck_pkg SHALL hold the gun_state_t enum (WAIT, MEASURE, DONE) and the DEBOUNCE_CYCLES/HIT_THRESHOLD defaults.
REQ-032 Debounce logic SHALL be one sub-module, debounce (synchronizer + counter + level), instanced once for the trigger.

Verification (DEBOUNCE_CYCLES=8, HIT_THRESHOLD=4)
REQ-033 trigger_raw held at 1 for 20 cycles -> trigger rises 10 cycles after input (2 sync + 8), one trigger_pulse, shot_count=1.
REQ-034 trigger_raw toggled every 3 cycles for 40 cycles -> trigger stays 0, no pulse, shot_count=0.
REQ-035 flash_active=1 for a frame with photo_raw high for 6 cycles -> detect=1 until the ending frame_tick, 0 after it, hit_count=1.
REQ-036 photo_raw high for 3 cycles in a flash frame, or 100 cycles with flash_active=0 -> detect never 1, hit_count=0.
REQ-037 4th photo-high cycle coincides with frame_tick -> no detect, hit_count unchanged, FSM WAIT.
REQ-038 shot_count at 255 plus one more pulse -> stays 255; rst mid-MEASURE -> all outputs 0 the next cycle.
